// File: rtl/muldiv_pkg.sv
// Shared encodings and sizes for the MULT/MULTU/DIV/DIVU sequencer.
//   op_e     : request opcode as presented by EXE
//   state_e  : sequencer FSM states
//   mag()    : two's-complement magnitude helper
package muldiv_pkg;

  localparam int unsigned XLEN_W    = 32;
  localparam int unsigned ACC_W     = 2 * XLEN_W;
  localparam int unsigned DIV_STEPS = 32;
  localparam int unsigned CNT_W     = 5;

  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // Absolute value when neg is set, raw value otherwise.
  function automatic logic [XLEN_W-1:0] mag(input logic [XLEN_W-1:0] x, input logic neg);
    return neg ? (~x + XLEN_W'(1)) : x;
  endfunction

endpackage

// File: rtl/muldiv_seq_ctrl_if.sv
// Request/result bus between EXE and the mul/div sequencer.
//   master : EXE side (drives req_*, res_ready)
//   slave  : sequencer side (drives req_ready, busy, res_*)
interface muldiv_seq_ctrl_if;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [31:0] req_src1;
  logic [31:0] req_src2;
  logic        req_ready;
  logic        busy;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  modport master (
    output req_valid, req_op, req_src1, req_src2, res_ready,
    input  req_ready, busy, res_valid, res_hi, res_lo
  );

  modport slave (
    input  req_valid, req_op, req_src1, req_src2, res_ready,
    output req_ready, busy, res_valid, res_hi, res_lo
  );
endinterface

// File: rtl/muldiv_step.sv
// One iteration of the mul/div datapath (combinational).
//   i_div  : 1 = restoring-divide step, 0 = shift-add multiply step
//   i_acc  : {hi,lo} accumulator ({partial,multiplier} or {rem,quo})
//   i_opnd : multiplicand or divisor magnitude
//   o_acc  : accumulator after this step
module muldiv_step
  import muldiv_pkg::*;
(
  input  logic              i_div,
  input  logic [ACC_W-1:0]  i_acc,
  input  logic [XLEN_W-1:0] i_opnd,
  output logic [ACC_W-1:0]  o_acc
);

  logic [XLEN_W:0]   w_sum;
  logic [XLEN_W:0]   w_trial;
  logic              w_ge;
  logic [XLEN_W-1:0] w_rem;

  always_comb begin
    // Multiply: add multiplicand into the top half when the current multiplier bit is set, then shift right.
    w_sum   = {1'b0, i_acc[ACC_W-1:XLEN_W]} + {1'b0, (i_acc[0] ? i_opnd : '0)};
    // Divide: the shifted partial remainder can need 33 bits before the subtract.
    w_trial = i_acc[ACC_W-1:XLEN_W-1];
    w_ge    = (w_trial >= {1'b0, i_opnd});
    w_rem   = w_trial[XLEN_W-1:0] - i_opnd;
    if (i_div) begin
      o_acc = w_ge ? {w_rem, i_acc[XLEN_W-2:0], 1'b1} : {i_acc[ACC_W-2:0], 1'b0};
    end else begin
      o_acc = {w_sum, i_acc[XLEN_W-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq_ctrl.sv
// Sequencer for MULT/MULTU/DIV/DIVU beside EXE; returns {hi,lo} for HI/LO.
//   clk, reset : clock, synchronous active-high reset
//   cancel     : WB flush, aborts any in-flight op
//   bus        : request/result handshake (slave side)
module muldiv_seq_ctrl
  import muldiv_pkg::*;
#(
  parameter bit          FAST_MUL = 1'b1,
  parameter int unsigned XLEN     = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cancel,
  muldiv_seq_ctrl_if.slave bus
);

  state_e            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              r_div, w_div_nxt;
  logic              r_neg_res, w_neg_res_nxt;
  logic              r_neg_rem, w_neg_rem_nxt;
  logic              r_div0, w_div0_nxt;
  logic [ACC_W-1:0]  r_acc, w_acc_nxt;
  logic [XLEN-1:0]   r_opnd, w_opnd_nxt;
  logic [XLEN-1:0]   r_hi, w_hi_nxt;
  logic [XLEN-1:0]   r_lo, w_lo_nxt;

  op_e               w_op;
  logic              w_signed, w_is_div, w_neg1, w_neg2, w_accept;
  logic [XLEN-1:0]   w_mag1, w_mag2, w_rem, w_quo;
  logic [ACC_W-1:0]  w_step, w_prod_mag, w_prod;

  muldiv_step u_step (
    .i_div  (r_div),
    .i_acc  (r_acc),
    .i_opnd (r_opnd),
    .o_acc  (w_step)
  );

  assign bus.req_ready = (r_state == S_IDLE) & ~cancel & ~reset;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.res_valid = (r_state == S_DONE);
  assign bus.res_hi    = r_hi;
  assign bus.res_lo    = r_lo;

  // Next-state and datapath update.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_div_nxt     = r_div;
    w_neg_res_nxt = r_neg_res;
    w_neg_rem_nxt = r_neg_rem;
    w_div0_nxt    = r_div0;
    w_acc_nxt     = r_acc;
    w_opnd_nxt    = r_opnd;
    w_hi_nxt      = r_hi;
    w_lo_nxt      = r_lo;

    w_op     = op_e'(bus.req_op);
    w_signed = (w_op == OP_MULT) || (w_op == OP_DIV);
    w_is_div = (w_op == OP_DIV) || (w_op == OP_DIVU);
    w_neg1   = w_signed & bus.req_src1[XLEN-1];
    w_neg2   = w_signed & bus.req_src2[XLEN-1];
    w_mag1   = mag(bus.req_src1, w_neg1);
    w_mag2   = mag(bus.req_src2, w_neg2);
    w_accept = bus.req_valid & bus.req_ready;

    w_prod_mag = (FAST_MUL && !r_div) ? (ACC_W'(r_opnd) * ACC_W'(r_acc[XLEN-1:0])) : r_acc;
    w_prod     = r_neg_res ? (~w_prod_mag + ACC_W'(1)) : w_prod_mag;
    w_rem      = mag(r_acc[ACC_W-1:XLEN], r_neg_rem);
    w_quo      = r_div0 ? '1 : mag(r_acc[XLEN-1:0], r_neg_res);

    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_div_nxt     = w_is_div;
          w_neg_res_nxt = w_neg1 ^ w_neg2;
          w_neg_rem_nxt = w_neg1;
          w_div0_nxt    = w_is_div && (bus.req_src2 == '0);
          w_cnt_nxt     = '0;
          // Divide keeps the dividend in the low half and shifts it left; multiply keeps the multiplier there.
          w_acc_nxt     = w_is_div ? {{XLEN{1'b0}}, w_mag1} : {{XLEN{1'b0}}, w_mag2};
          w_opnd_nxt    = w_is_div ? w_mag2 : w_mag1;
          w_state_nxt   = (FAST_MUL && !w_is_div) ? S_FIX : S_CALC;
        end
      end
      S_CALC: begin
        w_acc_nxt = w_step;
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (r_cnt == CNT_W'(DIV_STEPS - 1)) begin
          w_state_nxt = S_FIX;
        end
      end
      S_FIX: begin
        if (!cancel) begin
          w_hi_nxt = r_div ? w_rem : w_prod[ACC_W-1:XLEN];
          w_lo_nxt = r_div ? w_quo : w_prod[XLEN-1:0];
        end
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (bus.res_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (cancel) begin
      w_state_nxt = S_IDLE;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_div     <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_div0    <= 1'b0;
      r_acc     <= '0;
      r_opnd    <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_div     <= w_div_nxt;
      r_neg_res <= w_neg_res_nxt;
      r_neg_rem <= w_neg_rem_nxt;
      r_div0    <= w_div0_nxt;
      r_acc     <= w_acc_nxt;
      r_opnd    <= w_opnd_nxt;
      r_hi      <= w_hi_nxt;
      r_lo      <= w_lo_nxt;
    end
  end

endmodule
